// File: rtl/inv_key_schedule.sv
// ============================================================================
// Module   : inv_key_schedule
// Brief    : AES-128 decryption key scheduler emitting round keys 10 down to 0
//            from either the cipher key or the final round key.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sub_byte (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    logic [7:0] w_inv;

    always_comb begin
        w_inv    = gf_inv(in_byte);
        out_byte = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
                 ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
    end
endmodule

module inv_key_schedule #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         key_is_last,
    input  logic [127:0] key_in,
    input  logic         abort,
    output logic         busy,
    output logic [127:0] key_out,
    output logic [3:0]   round_out,
    output logic         key_valid,
    input  logic         key_ready,
    output logic         done
);
    typedef enum logic [1:0] {IDLE = 2'd0, FWD = 2'd1, EMIT = 2'd2} state_t;

    state_t       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [3:0]   round_q, round_d;
    logic         valid_q, valid_d;
    logic         done_q, done_d;

    logic [31:0]  w0, w1, w2, w3, w3_inv, sbox_in, sub_out, t;
    logic [3:0]   rcon_idx;
    logic [127:0] fwd_key, inv_key;

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sbox
            sub_byte u_sbox (.in_byte(sbox_in[8*gi +: 8]), .out_byte(sub_out[8*gi +: 8]));
        end
    endgenerate

    // The single SubWord datapath is shared: FWD rotates w3, EMIT rotates the recovered w3 = w7^w6
    always_comb begin
        w0       = key_q[127:96];
        w1       = key_q[95:64];
        w2       = key_q[63:32];
        w3       = key_q[31:0];
        w3_inv   = w3 ^ w2;
        sbox_in  = (state_q == FWD) ? {w3[23:0], w3[31:24]} : {w3_inv[23:0], w3_inv[31:24]};
        rcon_idx = (state_q == FWD) ? cnt_q : ((round_q == 4'd0) ? 4'd0 : round_q - 4'd1);
        t        = sub_out ^ {rcon(rcon_idx), 24'h0};
        fwd_key  = {w0 ^ t, w1 ^ w0 ^ t, w2 ^ w1 ^ w0 ^ t, w3 ^ w2 ^ w1 ^ w0 ^ t};
        inv_key  = {w0 ^ t, w1 ^ w0, w2 ^ w1, w3_inv};
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
        round_d = round_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        if (abort) begin
            state_d = IDLE;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        key_d = key_in;
                        if (key_is_last) begin
                            state_d = EMIT;
                            round_d = 4'(NR);
                            valid_d = 1'b1;
                        end else begin
                            state_d = FWD;
                            cnt_d   = 4'd0;
                        end
                    end
                end
                FWD: begin
                    key_d = fwd_key;
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'(NR - 1)) begin
                        state_d = EMIT;
                        round_d = 4'(NR);
                        valid_d = 1'b1;
                    end
                end
                EMIT: begin
                    if (key_ready) begin
                        if (round_q != 4'd0) begin
                            key_d   = inv_key;
                            round_d = round_q - 4'd1;
                        end else begin
                            state_d = IDLE;
                            valid_d = 1'b0;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            cnt_q   <= '0;
            round_q <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
            round_q <= round_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign key_out   = key_q;
    assign round_out = round_q;
    assign key_valid = valid_q;
    assign done      = done_q;
endmodule

`default_nettype wire

// File: tb/tb_inv_key_schedule.sv
// ============================================================================
// Module   : tb_inv_key_schedule
// Brief    : Self-checking bench for inv_key_schedule against a forward
//            key-expansion reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inv_key_schedule;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         key_is_last = 1'b0;
    logic [127:0] key_in = '0;
    logic         abort = 1'b0;
    logic         busy;
    logic [127:0] key_out;
    logic [3:0]   round_out;
    logic         key_valid;
    logic         key_ready = 1'b1;
    logic         done;

    int checks = 0;
    int errors = 0;

    logic [7:0]   sbox [0:255];
    logic [127:0] exp_rk [0:10];

    always #5 clk = ~clk;

    inv_key_schedule #(.NR(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key_is_last(key_is_last),
        .key_in(key_in), .abort(abort), .busy(busy), .key_out(key_out),
        .round_out(round_out), .key_valid(key_valid), .key_ready(key_ready), .done(done)
    );

    // Classic table generator walking the multiplicative group with generator 3
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox[0] = 8'h63;
    endtask

    task automatic expand(input logic [127:0] ck);
        logic [31:0] w [0:43];
        logic [31:0] tmp;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = ck[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]};
                tmp = tmp ^ {rc, 24'h0};
                rc  = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Runs one full schedule against exp_rk; bp adds random key_ready, poke adds stray starts
    task automatic drive_schedule(input bit is_last, input logic [127:0] kin, input bit bp, input bit poke);
        int  n;
        int  exp_round;
        bit  seen_first;
        bit  fin;
        start = 1'b1; key_is_last = is_last; key_in = kin; key_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0; exp_round = 10; seen_first = 0; fin = 0;
        while (!fin && n < 400) begin
            if (poke) begin
                start = ($urandom_range(0, 2) == 0);
                key_in = rand128();
                key_is_last = 1'($urandom_range(0, 1));
            end
            checks++;
            if (busy !== 1'b1) begin errors++; $display("FAIL busy_during_run: got %b want 1 (n=%0d)", busy, n); end
            if (seen_first && !bp) begin
                checks++;
                if (key_valid !== 1'b1) begin errors++; $display("FAIL back_to_back: key_valid got %b want 1 (n=%0d)", key_valid, n); end
            end
            if (key_valid === 1'b1) begin
                if (!seen_first) begin
                    seen_first = 1;
                    checks++;
                    if (n != (is_last ? 0 : 10)) begin errors++; $display("FAIL first_valid_latency: got %0d want %0d", n, is_last ? 0 : 10); end
                end
                checks++;
                if (key_out !== exp_rk[exp_round] || round_out !== 4'(exp_round)) begin
                    errors++;
                    $display("FAIL round_key: got r%0d %h want r%0d %h", round_out, key_out, exp_round, exp_rk[exp_round]);
                end
            end
            key_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (key_valid === 1'b1 && key_ready) begin
                if (exp_round == 0) fin = 1;
                else exp_round--;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        key_ready = 1'b1;
        checks++;
        if (!fin) begin errors++; $display("FAIL schedule_timeout: got %0d cycles want completion", n); end
        checks++;
        if (done !== 1'b1 || key_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL done_pulse: got done=%b valid=%b busy=%b want 1 0 0", done, key_valid, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL done_single_cycle: got %b want 0", done); end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (busy !== 1'b0 || key_valid !== 1'b0 || done !== 1'b0 || key_out !== '0 || round_out !== 4'd0) begin
            errors++; $display("FAIL reset_state: got busy=%b valid=%b done=%b key=%h round=%0d want all 0",
                               busy, key_valid, done, key_out, round_out);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fips_cipher();
        logic [127:0] ck;
        ck = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        expand(ck);
        exp_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        exp_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        exp_rk[0]  = ck;
        drive_schedule(1'b0, ck, 1'b0, 1'b0);
    endtask

    task automatic test_fips_last();
        expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
        drive_schedule(1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        logic [127:0] ck;
        for (int k = 0; k < 3; k++) begin
            ck = rand128();
            expand(ck);
            drive_schedule(1'b1, exp_rk[10], 1'b1, 1'b0);
        end
    endtask

    task automatic test_start_ignored();
        logic [127:0] ck;
        ck = rand128();
        expand(ck);
        drive_schedule(1'b0, ck, 1'b0, 1'b1);
        ck = rand128();
        expand(ck);
        drive_schedule(1'b1, exp_rk[10], 1'b1, 1'b1);
    endtask

    task automatic test_abort();
        logic [127:0] ck;
        int n;
        ck = rand128();
        expand(ck);
        start = 1'b1; key_is_last = 1'b0; key_in = ck; key_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!(key_valid === 1'b1 && round_out === 4'd5) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= 100) begin errors++; $display("FAIL abort_reach_round5: got timeout want round 5"); end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++;
        if (key_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || round_out !== 4'd5 || key_out !== exp_rk[5]) begin
            errors++; $display("FAIL abort_state: got valid=%b done=%b busy=%b r%0d %h want 0 0 0 r5 %h",
                               key_valid, done, busy, round_out, key_out, exp_rk[5]);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_no_done: got done=%b busy=%b want 0 0", done, busy); end
        ck = rand128();
        expand(ck);
        drive_schedule(1'b0, ck, 1'b0, 1'b0);
    endtask

    task automatic test_start_abort_idle();
        start = 1'b1; abort = 1'b1; key_is_last = 1'b1; key_in = rand128();
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || key_valid !== 1'b0) begin
            errors++; $display("FAIL start_abort_idle: got busy=%b valid=%b want 0 0", busy, key_valid);
        end
    endtask

    task automatic test_async_reset();
        logic [127:0] ck;
        ck = rand128();
        expand(ck);
        start = 1'b1; key_is_last = 1'b0; key_in = ck;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || key_valid !== 1'b0 || done !== 1'b0 || key_out !== '0 || round_out !== 4'd0) begin
            errors++; $display("FAIL async_reset: got busy=%b valid=%b done=%b key=%h r%0d want all 0",
                               busy, key_valid, done, key_out, round_out);
        end
        @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got busy=%b done=%b want 0 0", busy, done); end
        end
        drive_schedule(1'b0, ck, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [127:0] ck;
        for (int k = 0; k < 4; k++) begin
            ck = rand128();
            expand(ck);
            if (k % 2 == 0) drive_schedule(1'b0, ck, 1'($urandom_range(0, 1)), 1'b0);
            else            drive_schedule(1'b1, exp_rk[10], 1'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_fips_cipher();
        test_fips_last();
        test_backpressure();
        test_start_ignored();
        test_abort();
        test_start_abort_idle();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
